// File: rtl/pwm_pkg.sv
// Shared constants and the duty compare for the 16-channel PWM peripheral.
// Optional build macro PWM_DUTY_SHADOW_EN is consumed by pwm_peripheral.
package pwm_pkg;

    localparam int PWM_CNT_W        = 8;
    localparam int NUM_CH           = 16;
    localparam int PRESCALE_DEFAULT = 13;
    localparam int PRESC_W          = 12;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    // Full-scale duty must be solid high; a plain compare would drop count 255.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running prescaler and 8-bit PWM counter; tick marks the prescaler wrap.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 tick,
    output logic [PWM_CNT_W-1:0] pwm_counter
);

    logic [PRESC_W-1:0]   presc_d, presc_q;
    logic [PWM_CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        tick    = (presc_q == PRESC_W'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwm_counter = cnt_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM output block with per-channel enable and PWM-mode select.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at period boundaries.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT,
    parameter int NUM_CH   = pwm_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out
);

    logic                 tick;
    logic                 level;
    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic [PWM_CNT_W-1:0] duty_active;
    logic [NUM_CH-1:0]    en_out, en_pwm;
    logic [NUM_CH-1:0]    out_d, out_q;

    pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .pwm_counter (pwm_cnt)
    );

`ifdef PWM_DUTY_SHADOW_EN
    logic [PWM_CNT_W-1:0] duty_d, duty_q;

    // Load only as the counter rolls 255->0 so a period is never torn.
    always_comb begin
        duty_d = duty_q;
        if (tick && (pwm_cnt == {PWM_CNT_W{1'b1}}))
            duty_d = pwm_duty_cycle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty_q <= '0;
        else        duty_q <= duty_d;
    end

    assign duty_active = duty_q;
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign duty_active = pwm_duty_cycle;
`endif

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign level  = pwm_level(pwm_cnt, duty_active);

    // Disabled channels force 0, so the select bit cannot glitch them.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            out_d[i] = en_out[i] & (~en_pwm[i] | level);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral (default PRESCALE=13).
// Expected values follow PWM_DUTY_SHADOW_EN when the bench is built with it.
module tb_pwm_peripheral;

    localparam int PERIOD = 13 * 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hi1, hi2;

    pwm_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {eo_hi, eo_lo} = eo;
        {ep_hi, ep_lo} = ep;
    endtask

    // One clock; returns at the following falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk({tag, "_out"}, 32'(out), 32'h0);
        chk({tag, "_cnt"}, 32'(dut.pwm_cnt), 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        chk("rel_cnt", 32'(dut.pwm_cnt), 32'h0);
    endtask

    // With the shadow register, a new duty only shows after the next period boundary.
    task automatic align();
`ifdef PWM_DUTY_SHADOW_EN
        do step(); while (cyc % PERIOD != 0);
`endif
    endtask

    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (out[0] === 1'b1) highs++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        set_en(16'h0000, 16'h0000);
        duty = 8'h00;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_cnt", 32'(dut.pwm_cnt), 32'h0);
        set_en(16'hFFFF, 16'h0000);
        step();
        chk("reset_hold", 32'(out), 32'h0);
        release_reset();

        step();
        chk("static_ffff", 32'(out), 32'hFFFF);
        set_en(16'h00F0, 16'h0000);
        #1 chk("static_not_comb", 32'(out), 32'hFFFF);
        step();
        chk("static_00f0", 32'(out), 32'h00F0);

        set_en(16'h0000, 16'h0000);
        step();
        chk("disabled", 32'(out), 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_en(16'h0000, (i % 2 == 0) ? 16'hFFFF : 16'h0000);
            step();
            chk("dis_sel_toggle", 32'(out), 32'h0);
        end

        set_en(16'hFF00, 16'h0F00);
        duty = 8'h00;
        step();
        chk("mixed_duty0", 32'(out), 32'hF000);

        // Mid-run reset, then watch the first tick land on the 13th edge.
        set_en(16'hFFFF, 16'h0000);
        step();
        chk("pre_rst_out", 32'(out), 32'hFFFF);
        async_reset("rst2");
        set_en(16'h0001, 16'h0001);
        duty = 8'h80;
        release_reset();
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 11) chk("tick_k11", 32'(dut.u_timebase.tick), 32'h0);
            if (k == 12) begin
                chk("tick_k12", 32'(dut.u_timebase.tick), 32'h1);
                chk("cnt_k12", 32'(dut.pwm_cnt), 32'h0);
            end
            if (k == 13) chk("cnt_k13", 32'(dut.pwm_cnt), 32'h1);
        end

        // Duty 0x80: 1664 clk high then 1664 clk low.
        async_reset("rst3");
        release_reset();
        align();
        hi1 = 0;
        for (int k = 1; k <= PERIOD + 1; k++) begin
            step();
            if (k <= PERIOD && out[0] === 1'b1) hi1++;
            if (k == 1)          chk("d80_k1", 32'(out[0]), 32'h1);
            if (k == 1664)       chk("d80_last_high", 32'(out[0]), 32'h1);
            if (k == 1665)       chk("d80_first_low", 32'(out[0]), 32'h0);
            if (k == PERIOD)     chk("d80_period_end", 32'(out[0]), 32'h0);
            if (k == PERIOD + 1) chk("d80_next_period", 32'(out[0]), 32'h1);
        end
        chk("d80_high_count", 32'(hi1), 32'd1664);

        duty = 8'h00;
        align();
        count_high(2 * PERIOD, hi1);
        chk("d00_high_count", 32'(hi1), 32'd0);

        duty = 8'hFF;
        align();
        count_high(2 * PERIOD, hi1);
        chk("dff_high_count", 32'(hi1), 32'(2 * PERIOD));

        // Duty 0x40 -> 0xC0 while the counter sits at 100.
        async_reset("rst4");
        duty = 8'h40;
        release_reset();
        align();
        hi1 = 0;
        hi2 = 0;
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            step();
            if (out[0] === 1'b1) begin
                if (k <= PERIOD) hi1++;
                else             hi2++;
            end
            if (k == 1300) begin
                chk("dchg_before", 32'(out[0]), 32'h0);
                duty = 8'hC0;
            end
`ifdef PWM_DUTY_SHADOW_EN
            if (k == 1301) chk("dchg_after", 32'(out[0]), 32'h0);
`else
            if (k == 1301) chk("dchg_after", 32'(out[0]), 32'h1);
`endif
        end
`ifdef PWM_DUTY_SHADOW_EN
        chk("dchg_period1", 32'(hi1), 32'd832);
`else
        chk("dchg_period1", 32'(hi1), 32'd2028);
`endif
        chk("dchg_period2", 32'(hi2), 32'd2496);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
